// File: rtl/cpu_host_loader_pkg.sv
// Shared state encoding and helpers for the host-side CPU loader.
package cpu_host_loader_pkg;

    localparam int unsigned STATE_W = 3;
    // The CPU instruction register is stale for this many RUN cycles, so done is ignored there.
    localparam int unsigned DONE_MIN_CYCLES = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_LOADED  = 3'd2,
        S_START   = 3'd3,
        S_RUN     = 3'd4,
        S_HALTED  = 3'd5,
        S_TIMEOUT = 3'd6
    } state_e;

    function automatic logic cpu_owns_mem(input state_e s);
        return (s == S_START) || (s == S_RUN);
    endfunction

endpackage

// File: rtl/cpu_host_loader_out_fifo.sv
// Small result FIFO with a registered head word; a push is visible on the next cycle.
module cpu_host_loader_out_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok = push & (~full | pop_ok);
    assign head    = head_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        cnt_d  = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        // New head is the word being written when it lands in the next read slot.
        head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cpu_host_loader.sv
// Host loader: streams an image into memory, runs the CPU under a watchdog, buffers OUTR results.
module cpu_host_loader
    import cpu_host_loader_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              go,
    output logic              host_own,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              cpu_on,
    input  logic              done,
    input  logic              e_out_r,
    input  logic [DATA_W-1:0] out_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              err_ovf,
    output logic              err_tout
);

    localparam int unsigned RUN_W = $clog2(TIMEOUT) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_tout_q, err_tout_d;

    logic ld_open;
    logic xfer;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_drop;

    assign ld_open   = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign xfer      = ld_valid & ld_open;
    assign fifo_push = e_out_r & (state_q == S_RUN);
    assign fifo_pop  = res_valid & res_ready;
    assign fifo_drop = fifo_push & fifo_full & ~fifo_pop;

    cpu_host_loader_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (out_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (res_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            run_cnt_q  <= '0;
            err_ovf_q  <= 1'b0;
            err_tout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            run_cnt_q  <= run_cnt_d;
            err_ovf_q  <= err_ovf_d;
            err_tout_q <= err_tout_d;
        end
    end

    // Next state, load address, watchdog counter and sticky errors.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        run_cnt_d  = run_cnt_q;
        err_ovf_d  = err_ovf_q | fifo_drop;
        err_tout_d = err_tout_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    addr_d  = ADDR_W'(1);
                    state_d = ld_last ? S_LOADED : S_LOAD;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    if (ld_last) begin
                        state_d = S_LOADED;
                    end else if (addr_q == '1) begin
                        err_ovf_d = 1'b1;
                        state_d   = S_LOADED;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            S_LOADED: begin
                if (go) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                run_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
                if (done && (run_cnt_q >= RUN_W'(DONE_MIN_CYCLES))) begin
                    state_d = S_HALTED;
                end else if (run_cnt_q == RUN_W'(TIMEOUT - 1)) begin
                    err_tout_d = 1'b1;
                    state_d    = S_TIMEOUT;
                end
            end
            S_HALTED, S_TIMEOUT: begin
                if (go) begin
                    addr_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the state register; only the load handshake looks at inputs.
    always_comb begin
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        cpu_reset = ~cpu_owns_mem(state_q);
        host_own  = ~cpu_owns_mem(state_q);
        cpu_on    = 1'b0;
        case (state_q)
            S_IDLE, S_LOAD: begin
                ld_ready = 1'b1;
                mem_we   = ld_valid;
            end
            S_RUN: begin
                cpu_on = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = ld_data;
    assign res_valid = ~fifo_empty;
    assign busy      = (state_q != S_IDLE);
    assign err_ovf   = err_ovf_q;
    assign err_tout  = err_tout_q;

endmodule
